// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving an APB-style SETUP/ACCESS sequence,
// with a watchdog that force-completes accesses whose slave never asserts ready.
module apb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_stb,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_stb,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  ready,
  input  logic                  perr
);

  localparam int unsigned TCNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [TCNT_WIDTH-1:0]   tcnt_q, tcnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pdata_d;
  logic                    pwrite_d;
  logic [3:0]              pstb_d;
  logic                    psel_d, penable_d;
  logic                    m0_done_d, m1_done_d, m0_err_d, m1_err_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_d, m1_rdata_d;
  logic                    grant;
  logic                    fin;
  logic                    fin_err;
  logic [DATA_WIDTH-1:0]   fin_rdata;

  // Next-state, bus fields and completion results for the registered outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tcnt_d       = tcnt_q;
    paddr_d      = paddr;
    pdata_d      = pdata;
    pwrite_d     = pwrite;
    pstb_d       = pstb;
    psel_d       = psel;
    penable_d    = penable;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = '0;
    m1_rdata_d   = '0;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_rdata    = '0;
    // On a tie the port that did not win last time gets the bus.
    grant        = (m0_req && m1_req) ? ~last_grant_q : m1_req;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          last_grant_d = grant;
          paddr_d      = grant ? m1_addr  : m0_addr;
          pdata_d      = grant ? m1_wdata : m0_wdata;
          pwrite_d     = grant ? m1_write : m0_write;
          pstb_d       = grant ? m1_stb   : m0_stb;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        tcnt_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (ready) begin
          fin       = 1'b1;
          fin_err   = perr;
          fin_rdata = pwrite ? '0 : prdata;
        end else if (tcnt_q == TCNT_LAST) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      state_d   = IDLE;
      if (last_grant_q) begin
        m1_done_d  = 1'b1;
        m1_err_d   = fin_err;
        m1_rdata_d = fin_rdata;
      end else begin
        m0_done_d  = 1'b1;
        m0_err_d   = fin_err;
        m0_rdata_d = fin_rdata;
      end
    end
  end

  // State, watchdog, grant history and all outputs register here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tcnt_q       <= '0;
      paddr        <= '0;
      pdata        <= '0;
      pwrite       <= 1'b0;
      pstb         <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
      paddr        <= paddr_d;
      pdata        <= pdata_d;
      pwrite       <= pwrite_d;
      pstb         <= pstb_d;
      psel         <= psel_d;
      penable      <= penable_d;
      m0_done      <= m0_done_d;
      m1_done      <= m1_done_d;
      m0_err       <= m0_err_d;
      m1_err       <= m1_err_d;
      m0_rdata     <= m0_rdata_d;
      m1_rdata     <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Randomized bench for apb_arbiter against a transaction-level model of
// arbitration, phase timing, watchdog and result routing.
module tb_apb_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req   [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          wr    [2];
  logic [3:0]    stb   [2];
  logic          done_o  [2];
  logic [DW-1:0] rdata_o [2];
  logic          err_o   [2];
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic          pwrite;
  logic [3:0]    pstb;
  logic          psel, penable;
  logic [DW-1:0] prdata;
  logic          ready, perr;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = 1;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_write(wr[0]), .m0_stb(stb[0]),
    .m0_done(done_o[0]), .m0_rdata(rdata_o[0]), .m0_err(err_o[0]),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_write(wr[1]), .m1_stb(stb[1]),
    .m1_done(done_o[1]), .m1_rdata(rdata_o[1]), .m1_err(err_o[1]),
    .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .pstb(pstb),
    .psel(psel), .penable(penable),
    .prdata(prdata), .ready(ready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [3:0] s);
    req[i] = 1'b1; addr[i] = a; wdata[i] = d; wr[i] = w; stb[i] = s;
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  // Spec rule: single requester wins, ties go to the port that did not win last.
  function automatic int pick();
    if (req[0] && req[1]) return 1 - model_last;
    else if (req[0]) return 0;
    else return 1;
  endfunction

  task automatic check_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_done"}, 64'(done_o[i]), 64'd0);
      check({tag, "_err"}, 64'(err_o[i]), 64'd0);
      check({tag, "_rdata"}, 64'(rdata_o[i]), 64'd0);
    end
  endtask

  task automatic check_fields(input string tag, input int w);
    check({tag, "_paddr"}, 64'(paddr), 64'(addr[w]));
    check({tag, "_pdata"}, 64'(pdata), 64'(wdata[w]));
    check({tag, "_pwrite"}, 64'(pwrite), 64'(wr[w]));
    check({tag, "_pstb"}, 64'(pstb), 64'(stb[w]));
  endtask

  // Called at a negedge while the DUT is idle with requests already driven.
  // lat = ACCESS cycle in which the slave raises ready (> TO means never).
  task automatic serve(input int lat, input logic sl_err, input logic [DW-1:0] rdval,
                       output int w);
    int n;
    logic exp_err;
    logic [DW-1:0] exp_rd;
    w = pick();
    model_last = w;
    n = (lat <= TO) ? lat : TO;
    exp_err = (lat <= TO) ? sl_err : 1'b1;
    exp_rd  = (lat <= TO && !wr[w]) ? rdval : '0;
    for (int c = 1; c <= 2 + n; c++) begin
      @(negedge pclk);
      if (c == 1) begin
        check("setup_psel", 64'(psel), 64'd1);
        check("setup_penable", 64'(penable), 64'd0);
        check_fields("setup", w);
        check_quiet("setup");
        ready  = 1'($urandom_range(0, 1));
        perr   = 1'($urandom_range(0, 1));
        prdata = $urandom;
      end else if (c <= 1 + n) begin
        check("access_psel", 64'(psel), 64'd1);
        check("access_penable", 64'(penable), 64'd1);
        check_fields("access", w);
        check_quiet("access");
        ready  = (c - 1 == lat);
        perr   = (c - 1 == lat) ? sl_err : 1'($urandom_range(0, 1));
        prdata = (c - 1 == lat) ? rdval : $urandom;
      end else begin
        check("done_psel", 64'(psel), 64'd0);
        check("done_penable", 64'(penable), 64'd0);
        check("done_paddr_held", 64'(paddr), 64'(addr[w]));
        check("done_pulse", 64'(done_o[w]), 64'd1);
        check("done_err", 64'(err_o[w]), 64'(exp_err));
        check("done_rdata", 64'(rdata_o[w]), 64'(exp_rd));
        check("other_done", 64'(done_o[1-w]), 64'd0);
        check("other_err", 64'(err_o[1-w]), 64'd0);
        check("other_rdata", 64'(rdata_o[1-w]), 64'd0);
        ready  = 1'($urandom_range(0, 1));
        perr   = 1'($urandom_range(0, 1));
        prdata = $urandom;
      end
    end
    req[w] = 1'b0;
  endtask

  initial begin
    int w;
    int lat;
    presetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wr[i] = 1'b0; stb[i] = '0;
    end
    ready = 1'b0; perr = 1'b0; prdata = '0;
    repeat (2) @(negedge pclk);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pdata", 64'(pdata), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_pstb", 64'(pstb), 64'd0);
    check_quiet("rst");
    presetn = 1'b1;
    @(negedge pclk);

    // UART-style write from m0, then read from m1.
    set_req(0, 32'h1000_0000, 32'h0000_0041, 1'b1, 4'hF);
    serve(2, 1'b0, 32'hDEAD_BEEF, w);
    check("d1_winner", 64'(w), 64'd0);
    set_req(1, 32'h1000_0005, 32'h0, 1'b0, 4'h1);
    serve(2, 1'b0, 32'h0000_0060, w);
    check("d2_winner", 64'(w), 64'd1);

    // Both saturated: strict alternation, starting with m0.
    rand_req(0); rand_req(1);
    for (int k = 0; k < 4; k++) begin
      serve(2, 1'b0, $urandom, w);
      check("rr_order", 64'(w), 64'(k % 2));
      rand_req(w);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    @(negedge pclk);

    // Watchdog expiry, then a normal transfer.
    set_req(0, $urandom, $urandom, 1'b0, 4'hF);
    serve(100, 1'b0, $urandom, w);
    set_req(0, $urandom, $urandom, 1'b0, 4'hF);
    serve(1, 1'b0, 32'h1234_5678, w);
    // ready with perr exactly on the last allowed ACCESS cycle.
    set_req(1, $urandom, $urandom, 1'b0, 4'h3);
    serve(TO, 1'b1, 32'hCAFE_F00D, w);

    // Reset during ACCESS drops the transfer; m1 is re-arbitrated afterwards.
    set_req(1, 32'h2000_0010, 32'h55, 1'b0, 4'hF);
    repeat (2) @(negedge pclk);
    check("pre_rst_penable", 64'(penable), 64'd1);
    #2 presetn = 1'b0;
    #1;
    check("rst_mid_psel", 64'(psel), 64'd0);
    check("rst_mid_penable", 64'(penable), 64'd0);
    check_quiet("rst_mid");
    @(negedge pclk);
    check_quiet("rst_hold");
    presetn = 1'b1;
    model_last = 1;
    serve(2, 1'b0, 32'h0BAD_CAFE, w);
    check("post_rst_winner", 64'(w), 64'd1);

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 2; i++)
        if (!req[i] && $urandom_range(0, 2) != 0) rand_req(i);
      if (!req[0] && !req[1]) begin
        @(negedge pclk);
        check("idle_psel", 64'(psel), 64'd0);
        check_quiet("idle");
        ready = 1'($urandom_range(0, 1));
        perr  = 1'($urandom_range(0, 1));
      end else begin
        lat = $urandom_range(1, 6);
        if (lat == 6) lat = 50;
        serve(lat, 1'($urandom_range(0, 1)), $urandom, w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
